// File: rtl/stack_ctrl.sv
// Data-stack sequencing controller: owns the stack pointer and drives a 1-cycle-latency sync RAM.
// Optional saturating error counter enabled by defining STACK_CTRL_ERRCNT_EN.
module stack_ctrl #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  input  logic [DW-1:0] op_data,
  output logic          op_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   sp,
  output logic          full,
  output logic          empty,
  output logic [7:0]    err_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RDW  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [AW:0]   sp_q;
  logic [AW:0]   sp_m1;
  logic          pop_q;
  logic [DW-1:0] data_p0;
  logic          accept;

  assign accept   = op_valid && op_ready;
  assign op_ready = (state_q == S_IDLE);
  assign sp       = sp_q;
  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == '0);
  assign sp_m1    = sp_q - SP_ONE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_PUSH:         state_d = full  ? S_ERR : S_WR;
            OP_POP, OP_PEEK: state_d = empty ? S_ERR : S_RD;
            default:         state_d = S_IDLE;
          endcase
        end
      end
      S_WR:    state_d = S_IDLE;
      S_RD:    state_d = S_RDW;
      S_RDW:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: sp only moves in WR (push) and RD (pop); both are pre-qualified by full/empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        pop_q <= (op_code == OP_POP);
      if (state_q == S_WR)
        sp_q <= sp_q + SP_ONE;
      else if (state_q == S_RD && pop_q)
        sp_q <= sp_m1;
    end
  end

  // Push payload captured at acceptance
  always_ff @(posedge clk) begin
    if (accept)
      data_p0 <= op_data;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    case (state_q)
      S_WR: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q[AW-1:0];
        mem_wdata = data_p0;
        rsp_valid = 1'b1;
      end
      S_RD: begin
        mem_addr  = sp_m1[AW-1:0];
      end
      S_RDW: begin
        rsp_valid = 1'b1;
        rsp_data  = mem_rdata;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef STACK_CTRL_ERRCNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)
      err_cnt_q <= '0;
    else if (state_q == S_ERR)
      err_cnt_q <= sat_inc8(err_cnt_q);
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
